// File: rtl/simt_pkg.sv
// Shared types for the SIMT group's DMA command port: command encoding,
// sequencer states, and the word-alignment helper.
package simt_pkg;

   typedef enum logic [1:0] {
      NONE = 2'b00,
      D2S  = 2'b01,
      S2D  = 2'b10
   } dma_cmd_t;

   typedef enum logic [2:0] {
      IDLE,
      D2S_REQ,
      D2S_WAIT,
      D2S_WR,
      S2D_RD,
      S2D_WAIT,
      S2D_REQ,
      DONE
   } dma_state_t;

   localparam logic [31:0] WORD_BYTES = 32'd4;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// Source/destination address and word-count registers for dma_ctrl.
// Remaining count is a down-counter; last flags the final word.
module dma_addr_gen
   import simt_pkg::*;
#(
   parameter int WIDTH_W = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic [31:0]        src_init,
   input  logic [31:0]        dst_init,
   input  logic [WIDTH_W-1:0] width_init,
   output logic [31:0]        src,
   output logic [31:0]        dst,
   output logic               last
);

   logic [WIDTH_W-1:0] remaining;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         src       <= '0;
         dst       <= '0;
         remaining <= '0;
      end else if (load) begin
         src       <= word_align(src_init);
         dst       <= word_align(dst_init);
         remaining <= width_init;
      end else if (step) begin
         src       <= src + WORD_BYTES;
         dst       <= dst + WORD_BYTES;
         remaining <= remaining - WIDTH_W'(1);
      end
   end

   assign last = (remaining == WIDTH_W'(1));

endmodule

// File: rtl/dma_ctrl.sv
// Word-at-a-time DMA sequencer between DRAM and one SRAM port.
// Optional SRAM range check and sticky dmaError: define DMA_BOUNDS_CHECK_EN.
//
// state    | meaning
// IDLE     | waiting for an armed d2s/s2d command
// D2S_REQ  | DRAM read request held until dramReady
// D2S_WAIT | waiting for dramReadValid, capture word
// D2S_WR   | SRAM write of captured word, advance pointers
// S2D_RD   | SRAM address presented
// S2D_WAIT | capture SRAM read data
// S2D_REQ  | DRAM write request held until dramReady, advance pointers
// DONE     | one-cycle dmaDone pulse
module dma_ctrl
   import simt_pkg::*;
#(
   parameter int WIDTH_W    = 10,
   parameter int SRAM_BYTES = 65536
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         dmaCmd,
   input  logic [31:0]        dmaSrcAddress,
   input  logic [31:0]        dmaDstAddress,
   input  logic [WIDTH_W-1:0] dmaWidth,
   output logic               dmaBusy,
   output logic               dmaDone,
`ifdef DMA_BOUNDS_CHECK_EN
   output logic               dmaError,
`endif
   output logic [31:0]        sramAddress,
   output logic               sramWriteEnable,
   output logic [31:0]        sramWriteData,
   input  logic [31:0]        sramReadData,
   output logic [31:0]        dramAddress,
   output logic               dramReq,
   output logic               dramWe,
   output logic [31:0]        dramWriteData,
   input  logic               dramReady,
   input  logic               dramReadValid,
   input  logic [31:0]        dramReadData
);

   // The SRAM port decodes only bits [15:2]; the upper bits are kept clear.
   localparam logic [31:0] SRAM_MASK = 32'(SRAM_BYTES - 1);

   dma_state_t  state, state_nxt;
   logic        armed;
   logic        cmd_valid;
   logic        accept;
   logic        bad_range;
   logic        addr_step;
   logic [31:0] data;
   logic [31:0] src, dst;
   logic        last;

   assign cmd_valid = (dmaCmd == D2S) || (dmaCmd == S2D);
   assign accept    = (state == IDLE) && armed && cmd_valid;

`ifdef DMA_BOUNDS_CHECK_EN
   logic [31:0] sram_base;
   logic [33:0] range_end;
   assign sram_base = (dmaCmd == D2S) ? dmaDstAddress : dmaSrcAddress;
   assign range_end = {2'b00, word_align(sram_base)}
                    + {{(32-WIDTH_W){1'b0}}, dmaWidth, 2'b00};
   assign bad_range = range_end > 34'(SRAM_BYTES);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         dmaError <= 1'b0;
      else if (accept)
         dmaError <= bad_range;
   end
`else
   assign bad_range = 1'b0;
`endif

   dma_addr_gen #(.WIDTH_W(WIDTH_W)) u_addr_gen (
      .clk        (clk),
      .reset      (reset),
      .load       (accept),
      .step       (addr_step),
      .src_init   (dmaSrcAddress),
      .dst_init   (dmaDstAddress),
      .width_init (dmaWidth),
      .src        (src),
      .dst        (dst),
      .last       (last)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         armed <= 1'b1;
         data  <= '0;
      end else begin
         state <= state_nxt;
         if (!cmd_valid)
            armed <= 1'b1;
         else if (accept)
            armed <= 1'b0;
         if (state == D2S_WAIT && dramReadValid)
            data <= dramReadData;
         else if (state == S2D_WAIT)
            data <= sramReadData;
      end
   end

   always_comb begin
      state_nxt       = state;
      addr_step       = 1'b0;
      dmaBusy         = 1'b1;
      dmaDone         = 1'b0;
      sramAddress     = '0;
      sramWriteEnable = 1'b0;
      sramWriteData   = '0;
      dramAddress     = '0;
      dramReq         = 1'b0;
      dramWe          = 1'b0;
      dramWriteData   = '0;
      case (state)
         IDLE: begin
            dmaBusy = 1'b0;
            if (accept) begin
               if (dmaWidth == '0 || bad_range)
                  state_nxt = DONE;
               else if (dmaCmd == D2S)
                  state_nxt = D2S_REQ;
               else
                  state_nxt = S2D_RD;
            end
         end
         D2S_REQ: begin
            dramReq     = 1'b1;
            dramAddress = src;
            if (dramReady)
               state_nxt = D2S_WAIT;
         end
         D2S_WAIT: begin
            if (dramReadValid)
               state_nxt = D2S_WR;
         end
         D2S_WR: begin
            sramWriteEnable = 1'b1;
            sramAddress     = dst & SRAM_MASK;
            sramWriteData   = data;
            addr_step       = 1'b1;
            state_nxt       = last ? DONE : D2S_REQ;
         end
         S2D_RD: begin
            sramAddress = src & SRAM_MASK;
            state_nxt   = S2D_WAIT;
         end
         S2D_WAIT: begin
            state_nxt = S2D_REQ;
         end
         S2D_REQ: begin
            dramReq       = 1'b1;
            dramWe        = 1'b1;
            dramAddress   = dst;
            dramWriteData = data;
            if (dramReady) begin
               addr_step = 1'b1;
               state_nxt = last ? DONE : S2D_RD;
            end
         end
         DONE: begin
            dmaBusy   = 1'b0;
            dmaDone   = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            dmaBusy   = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dma_ctrl.sv
// Scoreboard bench for dma_ctrl: directed commands push expected memory
// events; a negedge monitor pops and compares whatever the DUT produces.
module tb_dma_ctrl;

   localparam int WIDTH_W = 10;

   localparam logic [1:0] EV_DRD  = 2'd0;
   localparam logic [1:0] EV_DWR  = 2'd1;
   localparam logic [1:0] EV_SWR  = 2'd2;
   localparam logic [1:0] EV_DONE = 2'd3;

   typedef struct {
      logic [1:0]  kind;
      logic [31:0] addr;
      logic [31:0] data;
   } ev_t;

   logic               clk = 1'b0;
   logic               reset;
   logic [1:0]         dmaCmd;
   logic [31:0]        dmaSrcAddress;
   logic [31:0]        dmaDstAddress;
   logic [WIDTH_W-1:0] dmaWidth;
   logic               dmaBusy;
   logic               dmaDone;
`ifdef DMA_BOUNDS_CHECK_EN
   logic               dmaError;
`endif
   logic [31:0]        sramAddress;
   logic               sramWriteEnable;
   logic [31:0]        sramWriteData;
   logic [31:0]        sramReadData;
   logic [31:0]        dramAddress;
   logic               dramReq;
   logic               dramWe;
   logic [31:0]        dramWriteData;
   logic               dramReady;
   logic               dramReadValid = 1'b0;
   logic [31:0]        dramReadData;

   dma_ctrl #(.WIDTH_W(WIDTH_W), .SRAM_BYTES(65536)) dut (
      .clk             (clk),
      .reset           (reset),
      .dmaCmd          (dmaCmd),
      .dmaSrcAddress   (dmaSrcAddress),
      .dmaDstAddress   (dmaDstAddress),
      .dmaWidth        (dmaWidth),
      .dmaBusy         (dmaBusy),
      .dmaDone         (dmaDone),
`ifdef DMA_BOUNDS_CHECK_EN
      .dmaError        (dmaError),
`endif
      .sramAddress     (sramAddress),
      .sramWriteEnable (sramWriteEnable),
      .sramWriteData   (sramWriteData),
      .sramReadData    (sramReadData),
      .dramAddress     (dramAddress),
      .dramReq         (dramReq),
      .dramWe          (dramWe),
      .dramWriteData   (dramWriteData),
      .dramReady       (dramReady),
      .dramReadValid   (dramReadValid),
      .dramReadData    (dramReadData)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int issue_cyc = 0;
   int bp       = 0;
   ev_t exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // ---------------- memory models ----------------
   logic [31:0] sram [0:16383];
   logic [31:0] dram [0:1023];
   logic        bd_we = 1'b0;
   logic        bd_dram = 1'b0;
   logic [13:0] bd_idx = '0;
   logic [31:0] bd_val = '0;
   int          req_cycles = 0;

   always @(posedge clk) begin
      if (bd_we && !bd_dram)
         sram[bd_idx] <= bd_val;
      else if (sramWriteEnable)
         sram[sramAddress[15:2]] <= sramWriteData;
      sramReadData <= sram[sramAddress[15:2]];
   end

   always @(posedge clk) begin
      dramReadValid <= 1'b0;
      if (bd_we && bd_dram)
         dram[bd_idx[9:0]] <= bd_val;
      else if (dramReq && dramReady) begin
         if (dramWe)
            dram[dramAddress[11:2]] <= dramWriteData;
         else begin
            dramReadValid <= 1'b1;
            dramReadData  <= dram[dramAddress[11:2]];
         end
      end
      if (dramReq && !dramReady)
         req_cycles <= req_cycles + 1;
      else
         req_cycles <= 0;
   end

   always_comb dramReady = (req_cycles >= bp);

   task automatic poke(input logic is_dram, input logic [13:0] idx, input logic [31:0] val);
      bd_dram = is_dram;
      bd_idx  = idx;
      bd_val  = val;
      bd_we   = 1'b1;
      @(posedge clk);
      #1 bd_we = 1'b0;
   endtask

   // ---------------- scoreboard monitor ----------------
   logic        hold_pend = 1'b0;
   logic [31:0] hold_addr = '0;
   logic [31:0] hold_data = '0;
   logic        hold_we   = 1'b0;

   task automatic observe(input logic [1:0] kind, input logic [31:0] addr, input logic [31:0] data);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d addr %h data %h, required none", kind, addr, data);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", 32'(kind), 32'(e.kind));
         check("event_addr", addr, e.addr);
         check("event_data", data, e.data);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            check("req_held",       32'(dramReq), 32'd1);
            check("req_addr_stable", dramAddress,  hold_addr);
            check("req_data_stable", dramWriteData, hold_data);
            check("req_we_stable",  32'(dramWe),  32'(hold_we));
         end
         hold_pend = dramReq && !dramReady;
         hold_addr = dramAddress;
         hold_data = dramWriteData;
         hold_we   = dramWe;
         if (dramReq && dramReady)
            observe(dramWe ? EV_DWR : EV_DRD, dramAddress, dramWe ? dramWriteData : 32'd0);
         if (sramWriteEnable)
            observe(EV_SWR, sramAddress, sramWriteData);
         if (dmaDone) begin
            check("busy_low_at_done", 32'(dmaBusy), 32'd0);
            observe(EV_DONE, 32'd0, 32'(cyc - issue_cyc));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic expect_ev(input logic [1:0] kind, input logic [31:0] addr, input logic [31:0] data);
      ev_t e;
      e.kind = kind;
      e.addr = addr;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic [1:0] cmd, input logic [31:0] src, input logic [31:0] dst,
                        input int width, input int hold);
      @(negedge clk);
      dmaCmd        = cmd;
      dmaSrcAddress = src;
      dmaDstAddress = dst;
      dmaWidth      = WIDTH_W'(width);
      issue_cyc     = cyc;
      repeat (hold) @(negedge clk);
      dmaCmd        = 2'b00;
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s: %0d events still outstanding after %0d cycles, required 0", name, exp_q.size(), n);
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required test completion");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      reset         = 1'b0;
      dmaCmd        = 2'b00;
      dmaSrcAddress = '0;
      dmaDstAddress = '0;
      dmaWidth      = '0;

      // reset values
      repeat (3) @(negedge clk);
      check("rst_busy",      32'(dmaBusy),         32'd0);
      check("rst_done",      32'(dmaDone),         32'd0);
      check("rst_sram_we",   32'(sramWriteEnable), 32'd0);
      check("rst_dram_req",  32'(dramReq),         32'd0);
      check("rst_dram_we",   32'(dramWe),          32'd0);
      check("rst_sram_addr", sramAddress,          32'd0);
      check("rst_sram_wd",   sramWriteData,        32'd0);
      check("rst_dram_addr", dramAddress,          32'd0);
      check("rst_dram_wd",   dramWriteData,        32'd0);
`ifdef DMA_BOUNDS_CHECK_EN
      check("rst_error",     32'(dmaError),        32'd0);
`endif
      reset = 1'b1;

      // d2s, 4 words, zero DRAM wait
      poke(1'b1, 14'h40, 32'd11);
      poke(1'b1, 14'h41, 32'd22);
      poke(1'b1, 14'h42, 32'd33);
      poke(1'b1, 14'h43, 32'd44);
      for (int i = 16; i < 20; i++) poke(1'b0, 14'(i), 32'hA5A5A5A5);
      expect_ev(EV_DRD, 32'h100, 32'd0);
      expect_ev(EV_SWR, 32'h40,  32'd11);
      expect_ev(EV_DRD, 32'h104, 32'd0);
      expect_ev(EV_SWR, 32'h44,  32'd22);
      expect_ev(EV_DRD, 32'h108, 32'd0);
      expect_ev(EV_SWR, 32'h48,  32'd33);
      expect_ev(EV_DRD, 32'h10C, 32'd0);
      expect_ev(EV_SWR, 32'h4C,  32'd44);
      expect_ev(EV_DONE, 32'd0,  32'd13);
      issue(2'b01, 32'h100, 32'h40, 4, 1);
      check("d2s_busy_after_accept", 32'(dmaBusy), 32'd1);
      drain("d2s_drain", 60);
      check("d2s_sram16", sram[16], 32'd11);
      check("d2s_sram17", sram[17], 32'd22);
      check("d2s_sram18", sram[18], 32'd33);
      check("d2s_sram19", sram[19], 32'd44);

      // s2d, 1 word, DRAM ready held low 2 cycles
      poke(1'b0, 14'h0, 32'hDEADBEEF);
      poke(1'b1, 14'h80, 32'h0);
      bp = 2;
      expect_ev(EV_DWR, 32'h200, 32'hDEADBEEF);
      expect_ev(EV_DONE, 32'd0,  32'd6);
      issue(2'b10, 32'h0, 32'h200, 1, 1);
      drain("s2d_drain", 40);
      bp = 0;
      check("s2d_dram_200", dram[10'h80], 32'hDEADBEEF);

      // zero length with command held, then re-arm
      expect_ev(EV_DONE, 32'd0, 32'd1);
      issue(2'b01, 32'h300, 32'h80, 0, 10);
      drain("zero_len_drain", 10);
      poke(1'b1, 14'hC0, 32'h12345678);
      expect_ev(EV_DRD, 32'h300, 32'd0);
      expect_ev(EV_SWR, 32'h80,  32'h12345678);
      expect_ev(EV_DONE, 32'd0,  32'd4);
      issue(2'b01, 32'h300, 32'h80, 1, 1);
      drain("rearm_drain", 30);
      check("rearm_sram32", sram[32], 32'h12345678);

      // reset during word 2 of a 4-word d2s
      for (int i = 0; i < 4; i++) poke(1'b1, 14'(8'h60 + i), 32'h0BAD0000 + 32'(i));
      for (int i = 0; i < 4; i++) poke(1'b0, 14'(14'h400 + i), 32'h5A5A5A5A);
      expect_ev(EV_DRD, 32'h180,  32'd0);
      expect_ev(EV_SWR, 32'h1000, 32'h0BAD0000);
      expect_ev(EV_DRD, 32'h184,  32'd0);
      issue(2'b01, 32'h180, 32'h1000, 4, 1);
      repeat (4) @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst_busy",     32'(dmaBusy),         32'd0);
      check("midrst_done",     32'(dmaDone),         32'd0);
      check("midrst_sram_we",  32'(sramWriteEnable), 32'd0);
      check("midrst_dram_req", 32'(dramReq),         32'd0);
      check("midrst_dram_addr", dramAddress,         32'd0);
      check("midrst_sram_addr", sramAddress,         32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      drain("midrst_drain", 5);
      repeat (15) @(negedge clk);
      check("midrst_word1", sram[14'h400], 32'h0BAD0000);
      check("midrst_word2", sram[14'h401], 32'h5A5A5A5A);
      check("midrst_word3", sram[14'h402], 32'h5A5A5A5A);
      check("midrst_word4", sram[14'h403], 32'h5A5A5A5A);

`ifdef DMA_BOUNDS_CHECK_EN
      // SRAM range overrun: straight to DONE, sticky error until next command
      expect_ev(EV_DONE, 32'd0, 32'd1);
      issue(2'b01, 32'h0, 32'hFFF8, 4, 1);
      drain("bounds_drain", 10);
      check("bounds_error_set", 32'(dmaError), 32'd1);
      expect_ev(EV_DRD, 32'h300, 32'd0);
      expect_ev(EV_SWR, 32'h84,  32'h12345678);
      expect_ev(EV_DONE, 32'd0,  32'd4);
      issue(2'b01, 32'h300, 32'h84, 1, 1);
      check("bounds_error_cleared", 32'(dmaError), 32'd0);
      drain("bounds_next_drain", 30);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
